// File: rtl/extend_scheduler.sv
// Feeds extend_array: walks a wavefront's diagonals, packs NUM_EXTEND lanes per
// FIFO word, and pops words into the engines only when every engine is idle.
module extend_scheduler #(
    parameter int NUM_EXTEND    = 8,
    parameter int TILE_SIZE     = 512,
    parameter int LOG_TILE_SIZE = $clog2(TILE_SIZE),
    parameter int TB_ADDR       = 10,
    parameter int FIFO_WIDTH    = 2*LOG_TILE_SIZE+TB_ADDR+2,
    parameter int GUARD         = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [LOG_TILE_SIZE:0]             k_lo,
    input  logic [LOG_TILE_SIZE:0]             k_hi,
    output logic                               wf_ren,
    output logic [LOG_TILE_SIZE:0]             wf_raddr,
    input  logic [LOG_TILE_SIZE+TB_ADDR:0]     wf_rdata,
    output logic                               fifo_wen,
    output logic [NUM_EXTEND*FIFO_WIDTH-1:0]   fifo_din,
    input  logic                               fifo_full,
    input  logic                               fifo_empty,
    output logic                               fifo_ren,
    input  logic [NUM_EXTEND-1:0]              is_finish,
    output logic                               busy,
    output logic                               done,
    output logic [LOG_TILE_SIZE:0]             batch_cnt
);

    localparam int KW = LOG_TILE_SIZE + 1;
    localparam int VB = LOG_TILE_SIZE + TB_ADDR;
    localparam int LW = (NUM_EXTEND > 1) ? $clog2(NUM_EXTEND) : 1;
    localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, PUSH, FLUSH} state_t;

    state_t state, state_nxt;

    logic signed [KW-1:0] k_lo_r;
    logic signed [KW-1:0] k_hi_r;
    logic signed [KW-1:0] k_cur;
    logic                 issuing;
    logic                 range_end;
    logic [LW-1:0]        rd_cnt;
    logic [LW-1:0]        lane_cnt;
    logic                 vld_p1;
    logic signed [KW-1:0] k_p1;
    logic [NUM_EXTEND*FIFO_WIDTH-1:0] lane_buf;
    logic [GW-1:0]        guard_cnt;
    logic [KW-1:0]        popped;
    logic                 pop_go;
    logic                 flush_ok;
    logic                 start_go;

    assign start_go = (state == IDLE) && start;
    assign pop_go   = (guard_cnt == '0) && !fifo_empty && (&is_finish);
    assign flush_ok = (popped == batch_cnt) && fifo_empty && (guard_cnt == '0) && (&is_finish);
    assign fifo_din = lane_buf;
    assign wf_raddr = wf_ren ? (k_cur - k_lo_r) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wf_ren    = 1'b0;
        fifo_wen  = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = ($signed(k_lo) <= $signed(k_hi)) ? FETCH : FLUSH;
            end
            FETCH: begin
                wf_ren = issuing;
                // last read issued and its data is being captured this cycle
                if (!issuing && vld_p1) state_nxt = PUSH;
            end
            PUSH: begin
                if (!fifo_full) begin
                    fifo_wen  = 1'b1;
                    state_nxt = range_end ? FLUSH : FETCH;
                end
            end
            FLUSH: begin
                if (flush_ok) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p0: read issue, k walk and batch bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_lo_r    <= '0;
            k_hi_r    <= '0;
            k_cur     <= '0;
            issuing   <= 1'b0;
            range_end <= 1'b0;
            rd_cnt    <= '0;
            batch_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k_lo_r    <= $signed(k_lo);
                        k_hi_r    <= $signed(k_hi);
                        k_cur     <= $signed(k_lo);
                        issuing   <= 1'b1;
                        range_end <= 1'b0;
                        rd_cnt    <= '0;
                        batch_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                FETCH: begin
                    if (issuing) begin
                        k_cur  <= k_cur + KW'(1);
                        rd_cnt <= rd_cnt + 1'b1;
                        if (k_cur == k_hi_r) range_end <= 1'b1;
                        if ((k_cur == k_hi_r) || (rd_cnt == LW'(NUM_EXTEND - 1)))
                            issuing <= 1'b0;
                    end
                end
                PUSH: begin
                    if (!fifo_full) begin
                        batch_cnt <= batch_cnt + 1'b1;
                        rd_cnt    <= '0;
                        issuing   <= !range_end;
                    end
                end
                FLUSH: begin
                    if (flush_ok) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // p1: capture returned wavefront data into the lane buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1   <= 1'b0;
            k_p1     <= '0;
            lane_cnt <= '0;
            lane_buf <= '0;
        end else begin
            vld_p1 <= wf_ren;
            k_p1   <= k_cur;
            if (vld_p1) begin
                lane_buf[int'(lane_cnt)*FIFO_WIDTH +: FIFO_WIDTH] <=
                    {wf_rdata[VB], k_p1, wf_rdata[VB-1:0]};
                lane_cnt <= lane_cnt + 1'b1;
            end else if (state == PUSH && !fifo_full) begin
                lane_buf <= '0;
                lane_cnt <= '0;
            end
        end
    end

    // dispatch: one pop per guard window, only with every engine idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_ren  <= 1'b0;
            guard_cnt <= '0;
            popped    <= '0;
        end else begin
            fifo_ren <= pop_go;
            if (pop_go)
                guard_cnt <= GW'(GUARD);
            else if (guard_cnt != '0)
                guard_cnt <= guard_cnt - 1'b1;
            if (start_go)
                popped <= '0;
            else if (pop_go)
                popped <= popped + 1'b1;
        end
    end

endmodule

// File: tb/tb_extend_scheduler.sv
// Directed bench for extend_scheduler with a behavioural wavefront memory and
// FIFO occupancy model.
module tb_extend_scheduler;

    logic         clk;
    logic         rst;
    logic         start;
    logic [9:0]   k_lo;
    logic [9:0]   k_hi;
    logic         wf_ren;
    logic [9:0]   wf_raddr;
    logic [19:0]  wf_rdata;
    logic         fifo_wen;
    logic [239:0] fifo_din;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_ren;
    logic [7:0]   is_finish;
    logic         busy;
    logic         done;
    logic [9:0]   batch_cnt;

    extend_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .k_lo(k_lo), .k_hi(k_hi),
        .wf_ren(wf_ren), .wf_raddr(wf_raddr), .wf_rdata(wf_rdata),
        .fifo_wen(fifo_wen), .fifo_din(fifo_din), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .fifo_ren(fifo_ren), .is_finish(is_finish),
        .busy(busy), .done(done), .batch_cnt(batch_cnt)
    );

    int ncmp = 0;
    int nerr = 0;
    int cyc = 0;
    int fcnt = 0;
    logic full_force;

    int nw = 0, nr = 0, nd = 0, nrd = 0;
    int done_cyc = 0;
    logic [239:0] words [0:15];
    int wen_cyc [0:15];
    int ren_cyc [0:15];
    logic push_pend = 0, pop_pend = 0, rd_pend = 0;
    logic [9:0] rd_addr = 0;

    assign fifo_full  = full_force;
    assign fifo_empty = (fcnt == 0);

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [8:0] off_of(input int a);
        return 9'(a * 3 + 1);
    endfunction

    function automatic logic [9:0] tb_of(input int a);
        return 10'(a + 100);
    endfunction

    function automatic logic [239:0] exp_word(input int kl, input int ks, input int n);
        logic [239:0] w;
        logic [9:0] kk;
        int k, a;
        w = '0;
        for (int i = 0; i < n; i++) begin
            k  = ks + i;
            a  = k - kl;
            kk = k[9:0];
            w[i*30 +: 30] = {1'b1, kk, off_of(a), tb_of(a)};
        end
        return w;
    endfunction

    // observe the second half of each cycle, then apply FIFO/memory effects just after the edge
    always @(negedge clk) begin
        #1;
        push_pend = fifo_wen && !fifo_full;
        pop_pend  = fifo_ren;
        rd_pend   = wf_ren;
        rd_addr   = wf_raddr;
        if (push_pend) begin
            if (nw < 16) begin
                words[nw]   = fifo_din;
                wen_cyc[nw] = cyc + 1;
            end
            nw++;
        end
        if (fifo_ren) begin
            if (nr < 16) ren_cyc[nr] = cyc + 1;
            nr++;
        end
        if (wf_ren) nrd++;
        if (done) begin
            nd++;
            done_cyc = cyc + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (push_pend) fcnt++;
        if (pop_pend && fcnt > 0) fcnt--;
        if (rd_pend) wf_rdata = {1'b1, off_of(int'(rd_addr)), tb_of(int'(rd_addr))};
        push_pend = 0;
        pop_pend  = 0;
        rd_pend   = 0;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        ncmp++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input int kl, input int kh, output int t);
        k_lo  = kl[9:0];
        k_hi  = kh[9:0];
        start = 1;
        t     = cyc + 1;
        @(negedge clk);
        start = 0;
    endtask

    initial begin
        int t, rel, bw, br, bd, brd;
        logic bad_din, bad_ren, bad_wen;
        logic [239:0] bp_word;

        rst = 0; start = 0; k_lo = 0; k_hi = 0;
        full_force = 0; is_finish = 8'hFF; wf_rdata = 0;
        tick(3);
        chk("rst_wf_ren", wf_ren, 0);
        chk("rst_wf_raddr", wf_raddr, 0);
        chk("rst_fifo_wen", fifo_wen, 0);
        chk("rst_fifo_din", fifo_din, 0);
        chk("rst_fifo_ren", fifo_ren, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_batch_cnt", batch_cnt, 0);
        rst = 1;
        tick(2);

        // full single batch, engine 3 held busy
        is_finish = 8'hF7;
        bw = nw; br = nr; bd = nd; brd = nrd;
        do_start(-3, 4, t);
        chk("t1_busy", busy, 1);
        chk("t1_wf_ren", wf_ren, 1);
        chk("t1_raddr0", wf_raddr, 0);
        tick(19);
        chk("t1_pushes", nw - bw, 1);
        chk("t1_wen_cycle", wen_cyc[bw], t + 10);
        chk("t1_word", words[bw], exp_word(-3, -3, 8));
        chk("t1_lane0_k", words[bw][28:19], 10'h3FD);
        chk("t1_lane7_k", words[bw][7*30+19 +: 10], 10'd4);
        chk("t1_batch_cnt", batch_cnt, 1);
        chk("t1_reads", nrd - brd, 8);
        chk("t1_gated_no_ren", nr - br, 0);
        chk("t1_no_done_yet", nd - bd, 0);
        rel = cyc + 1;
        is_finish = 8'hFF;
        tick(10);
        chk("t1_ren_count", nr - br, 1);
        chk("t1_ren_cycle", ren_cyc[br], rel + 1);
        chk("t1_done_count", nd - bd, 1);
        chk("t1_done_cycle", done_cyc, rel + 6);
        chk("t1_busy_low", busy, 0);

        // partial batch, with an ignored start while busy
        bw = nw; br = nr; bd = nd;
        do_start(0, 9, t);
        tick(2);
        k_lo = 10'd100; k_hi = 10'd120; start = 1;
        tick(1);
        start = 0;
        tick(22);
        chk("t2_pushes", nw - bw, 2);
        chk("t2_word0", words[bw], exp_word(0, 0, 8));
        chk("t2_word1", words[bw+1], exp_word(0, 8, 2));
        chk("t2_word1_hi_zero", words[bw+1][239:60], 0);
        chk("t2_wen1_cycle", wen_cyc[bw+1], t + 14);
        chk("t2_batch_cnt", batch_cnt, 2);
        chk("t2_ren_count", nr - br, 2);
        chk("t2_pop_spacing", (ren_cyc[br+1] - ren_cyc[br]) >= 5, 1);
        chk("t2_done_count", nd - bd, 1);
        chk("t2_done_cycle", done_cyc, t + 22);

        // empty range
        bw = nw; bd = nd; brd = nrd;
        do_start(2, 1, t);
        tick(5);
        chk("t3_done_count", nd - bd, 1);
        chk("t3_done_cycle", done_cyc, t + 2);
        chk("t3_no_reads", nrd - brd, 0);
        chk("t3_no_push", nw - bw, 0);
        chk("t3_batch_cnt", batch_cnt, 0);

        // back-pressure for 20 cycles of PUSH
        bw = nw; bd = nd;
        bp_word = exp_word(10, 10, 8);
        full_force = 1;
        do_start(10, 17, t);
        tick(9);
        bad_din = 0; bad_ren = 0; bad_wen = 0;
        for (int i = 0; i < 20; i++) begin
            if (fifo_din !== bp_word) bad_din = 1;
            if (wf_ren !== 1'b0) bad_ren = 1;
            if (fifo_wen !== 1'b0) bad_wen = 1;
            @(negedge clk);
        end
        full_force = 0;
        chk("t4_din_stable", bad_din, 0);
        chk("t4_wf_ren_low", bad_ren, 0);
        chk("t4_no_wen_while_full", bad_wen, 0);
        tick(15);
        chk("t4_pushes", nw - bw, 1);
        chk("t4_wen_cycle", wen_cyc[bw], t + 30);
        chk("t4_word", words[bw], bp_word);
        chk("t4_done_count", nd - bd, 1);

        // reset during fetch, then a fresh wavefront
        bd = nd;
        do_start(20, 27, t);
        tick(5);
        rst = 0;
        #1;
        chk("t5_rst_ctrl", {wf_ren, wf_raddr, fifo_wen, fifo_ren, busy, done, batch_cnt}, 0);
        chk("t5_rst_din", fifo_din, 0);
        @(negedge clk);
        tick(1);
        rst = 1;
        tick(3);
        chk("t5_no_done", nd - bd, 0);
        chk("t5_busy_low", busy, 0);
        bw = nw; bd = nd;
        do_start(-2, 5, t);
        tick(25);
        chk("t5_pushes", nw - bw, 1);
        chk("t5_word", words[bw], exp_word(-2, -2, 8));
        chk("t5_done_count", nd - bd, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/extend_scheduler.md
# extend_scheduler

Sequencer that feeds `extend_array`. On `start` it walks one wavefront's diagonals `k_lo..k_hi`, reads each diagonal's `{valid, offset, tbaddr}` from wavefront memory, and packs `NUM_EXTEND` lanes per word into the extend FIFO. It pops FIFO words into the extend engines only when every engine reports finished, and it pulses `done` once the whole wavefront has been extended.

## Interface
- `NUM_EXTEND`, 8, lanes per FIFO word and engines in the array
- `TILE_SIZE`, 512, tile dimension; `LOG_TILE_SIZE` = $clog2(TILE_SIZE)
- `TB_ADDR`, 10, traceback address width
- `FIFO_WIDTH`, 2*LOG_TILE_SIZE+TB_ADDR+2, lane width {is_valid, k, offset, tbaddr}
- `GUARD`, 4, cycles after `fifo_ren` before `is_finish` is trusted
---
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle pulse; begin a wavefront (ignored while `busy`)
- `k_lo`, `k_hi`  in  LOG_TILE_SIZE+1  signed diagonal range, sampled on `start`
- `wf_ren`  out  1  wavefront memory read enable
- `wf_raddr`  out  LOG_TILE_SIZE+1  read address = k − k_lo
- `wf_rdata`  in  LOG_TILE_SIZE+TB_ADDR+1  {valid, offset, tbaddr}; valid 1 cycle after `wf_ren`
- `fifo_wen`  out  1  push packed word
- `fifo_din`  out  NUM_EXTEND*FIFO_WIDTH  lane i at [(i+1)*FIFO_WIDTH−1 : i*FIFO_WIDTH]
- `fifo_full`, `fifo_empty`  in  1  extend FIFO status
- `fifo_ren`  out  1  pop one word into the engines
- `is_finish`  in  NUM_EXTEND  per-engine idle flags
- `busy`  out  1  wavefront in progress
- `done`  out  1  one-cycle pulse at completion
- `batch_cnt`  out  LOG_TILE_SIZE+1  words pushed for the current wavefront

## Operation
- **Fill FSM states:** IDLE, FETCH, PUSH, FLUSH.
- **IDLE:**
  - On `start`, latch `k_lo`/`k_hi`, clear `batch_cnt`, set `busy`.
  - Go to FETCH if k_lo ≤ k_hi (signed compare). Otherwise go straight to FLUSH.
- **FETCH:**
  - Issue one read per cycle: `wf_ren`=1, `wf_raddr`=k−k_lo, k increments.
  - Each returned `wf_rdata` is written into lane `lane_cnt` as {valid, k_of_that_read, offset, tbaddr}.
  - Leave FETCH after NUM_EXTEND reads, or after the read with k=k_hi.
  - After the last capture, go to PUSH. Lanes never written hold all-zero, so is_valid=0.
- **PUSH:**
  - Assert `fifo_wen` only when !`fifo_full`, then increment `batch_cnt` and clear the lane buffer.
  - If k passed k_hi, go to FLUSH. Otherwise go to FETCH.
  - While `fifo_full`, hold `fifo_din` stable and keep `wf_ren` low.
- **Dispatch (independent of the fill FSM):**
  - Pulse `fifo_ren` for one cycle when !`fifo_empty`, &`is_finish`, and `guard_cnt`=0.
  - Each pulse loads `guard_cnt`=GUARD, which decrements to 0.
  - Increment `popped` on each pulse.
  - `fifo_ren` and `fifo_wen` may be asserted in the same cycle.
- **FLUSH:**
  - Wait for `popped`==`batch_cnt`, `fifo_empty`, `guard_cnt`=0 and &`is_finish`.
  - When all hold, pulse `done`, clear `busy`, return to IDLE.
- **Widths and wrap:**
  - All k arithmetic is two's complement in LOG_TILE_SIZE+1 bits.
  - The range never exceeds TILE_SIZE diagonals, so `wf_raddr` does not wrap.
- **`start` while busy** is ignored and does not disturb the current wavefront.
- **Reset:** `rst` low at any time clears all outputs, counters and lane buffers asynchronously to 0, and the FSM to IDLE. A wavefront in flight is abandoned and no `done` is produced.

## Timing
- **Reset values:** `wf_ren`, `wf_raddr`, `fifo_wen`, `fifo_din`, `fifo_ren`, `busy`, `done`, `batch_cnt` all 0.
- **`start` → first read:**
  - `start` is sampled high at edge t. `busy`=1 and `wf_ren`=1 in cycle t+1.
  - For a full batch, reads occupy cycles t+1..t+NUM_EXTEND.
  - The last read's data is captured at the end of t+NUM_EXTEND+1.
  - `fifo_wen` is high in cycle t+NUM_EXTEND+2 if the FIFO is not full.
- **Batch period:** NUM_EXTEND+2 cycles with no back-pressure. The next FETCH begins the cycle after `fifo_wen`.
- **Pop spacing:** consecutive `fifo_ren` pulses are at least GUARD+1 cycles apart.
- **Outputs are registered:** `done` is asserted the cycle after the FLUSH conditions are seen, and `busy` falls in that same cycle.

## Test plan
- **Full single batch:** NUM_EXTEND=8, k_lo=−3, k_hi=4, all valid.
  - Exactly one `fifo_wen`, in cycle t+10.
  - Lane 0 k=−3 and lane 7 k=4; `batch_cnt`=1.
  - One `fifo_ren`; `done` after &`is_finish` returns.
- **Partial batch:** k_lo=0, k_hi=9.
  - Two pushes; the second has lanes 0–1 valid and lanes 2–7 all-zero.
  - `done` only after both words have been popped.
- **Empty range:** k_lo=2, k_hi=1.
  - No `wf_ren` and no `fifo_wen`; `done` in cycle t+2; `batch_cnt`=0.
- **Back-pressure:** `fifo_full`=1 for 20 cycles during PUSH.
  - `fifo_din` stays stable and `wf_ren` stays 0 throughout.
  - Push occurs in the first cycle `fifo_full` is 0.
- **Engine gating:** hold `is_finish[3]`=0 with the FIFO non-empty.
  - No `fifo_ren` is issued.
  - After release, `fifo_ren` fires once, and the next pulse is no earlier than GUARD+1 cycles later.
- **Reset mid-fetch:** drive `rst` low at lane 5.
  - All outputs go to 0 immediately.
  - After release, a fresh `start` produces correct lanes starting from lane 0.
